// File: rtl/pc_ctrl_pkg.sv
// Shared constants for the PC redirect / fetch sequencing control block.
// State codes are plain localparams so legacy code can compare against them directly.
package pc_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int PC_INC     = 4;

    typedef logic [1:0] pc_state_t;

    localparam pc_state_t ST_RUN    = 2'd0;
    localparam pc_state_t ST_DRAIN  = 2'd1;
    localparam pc_state_t ST_HALTED = 2'd2;

endpackage

// File: rtl/pc_redirect_ctrl_hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination feeds the ID
// instruction forces a one-cycle stall. Register x0 never creates a hazard.
module hazard_detect
    import pc_ctrl_pkg::*;
(
    input  logic                  idex_mem_read,
    input  logic [REG_ADDR_W-1:0] idex_rd,
    input  logic [REG_ADDR_W-1:0] ifid_rs1,
    input  logic [REG_ADDR_W-1:0] ifid_rs2,
    output logic                  load_use_stall
);

    always_comb begin
        load_use_stall = idex_mem_read
                       && (idex_rd != '0)
                       && ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC register, fetch sequencing and halt/drain FSM for the 5-stage core.
// Optional taken-redirect counter is built when PC_REDIRECT_PERF_EN is defined.
module pc_redirect_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int PC_W         = 9,
    parameter int RESET_PC     = 0,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  br_pc_sel,
    input  logic [31:0]           br_target,
    input  logic                  ex_valid,
    input  logic                  idex_mem_read,
    input  logic [REG_ADDR_W-1:0] idex_rd,
    input  logic [REG_ADDR_W-1:0] ifid_rs1,
    input  logic [REG_ADDR_W-1:0] ifid_rs2,
    input  logic                  mem_busy,
    input  logic                  halt_req,
    input  logic                  resume,
    output logic [PC_W-1:0]       pc,
    output logic                  ifid_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  pipe_hold,
    output logic                  halted,
    output logic [31:0]           redirect_count
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    pc_state_t        state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic             load_use_stall;
    logic             redirect;
    logic             redirect_fire;
    logic             unused_br_bits;

    assign redirect       = br_pc_sel && ex_valid;
    assign unused_br_bits = ^br_target[31:PC_W];

    hazard_detect u_hazard_detect (
        .idex_mem_read  (idex_mem_read),
        .idex_rd        (idex_rd),
        .ifid_rs1       (ifid_rs1),
        .ifid_rs2       (ifid_rs2),
        .load_use_stall (load_use_stall)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drain_cnt_d   = drain_cnt_q;
        redirect_fire = 1'b0;
        ifid_en       = 1'b0;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        pipe_hold     = 1'b0;
        halted        = 1'b0;

        case (state_q)
            ST_RUN: begin
                // A frozen EX keeps presenting its branch, so it is honoured after mem_busy drops
                if (mem_busy) begin
                    pipe_hold = 1'b1;
                end else begin
                    if (redirect) begin
                        pc_d          = br_target[PC_W-1:0];
                        ifid_flush    = 1'b1;
                        idex_flush    = 1'b1;
                        redirect_fire = 1'b1;
                    end else if (load_use_stall) begin
                        idex_flush = 1'b1;
                    end else if (!halt_req) begin
                        pc_d    = pc_q + PC_W'(PC_INC);
                        ifid_en = 1'b1;
                    end
                    if (halt_req) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = '0;
                    end
                end
            end
            ST_DRAIN: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                pipe_hold  = mem_busy;
                // Late redirects still land so the resume address is correct
                if (redirect) begin
                    pc_d          = br_target[PC_W-1:0];
                    redirect_fire = 1'b1;
                end
                if (!mem_busy) begin
                    if (drain_cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
                        state_d     = ST_HALTED;
                        drain_cnt_d = '0;
                    end else begin
                        drain_cnt_d = drain_cnt_q + 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                halted     = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                if (resume) begin
                    state_d     = ST_RUN;
                    drain_cnt_d = '0;
                end
            end
            default: begin
                state_d     = ST_RUN;
                drain_cnt_d = '0;
            end
        endcase

        if (reset) begin
            ifid_en       = 1'b0;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            pipe_hold     = 1'b0;
            halted        = 1'b0;
            redirect_fire = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            pc_q        <= PC_W'(RESET_PC);
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    assign pc = pc_q;

`ifdef PC_REDIRECT_PERF_EN
    logic [31:0] redirect_count_q, redirect_count_d;

    always_comb begin
        redirect_count_d = redirect_count_q + {31'd0, redirect_fire};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_count_q <= '0;
        end else begin
            redirect_count_q <= redirect_count_d;
        end
    end

    assign redirect_count = redirect_count_q;
`else
    logic unused_redirect_fire;

    assign unused_redirect_fire = redirect_fire;
    assign redirect_count       = '0;
`endif

endmodule
